// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst initiator with pass-through W/R streams.
// Define AXI_MASTER_LAT_CNT_EN to add the lat_cycles read-latency counter port.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic                  done_err,
`ifdef AXI_MASTER_LAT_CNT_EN
  output logic [15:0]           lat_cycles,
`endif
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(AXI_ID);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, err_q, err_d;
  logic done_valid_q, done_valid_d, done_err_q, done_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [8:0] beat_cnt_q, beat_cnt_d;
  logic cmd_hs, w_hs, r_hs, at_last, r_bad;
  assign cmd_hs  = cmd_valid & cmd_ready_q;
  assign w_hs    = (state_q == W) & wr_valid & m_axi_wready;
  assign r_hs    = (state_q == R) & m_axi_rvalid & rd_ready;
  assign at_last = beat_cnt_q == {1'b0, len_q};
  // an rlast on the wrong beat, or a missing one on beat len, is a protocol error
  assign r_bad   = (m_axi_rresp != 2'b00) | (m_axi_rid != ID) | (m_axi_rlast != at_last);
  assign cmd_ready     = cmd_ready_q;
  assign done_valid    = done_valid_q;
  assign done_err      = done_err_q;
  assign m_axi_awid    = ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = state_q == AW;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign m_axi_wlast   = at_last;
  assign m_axi_wvalid  = (state_q == W) & wr_valid;
  assign wr_ready      = (state_q == W) & m_axi_wready;
  assign m_axi_bready  = state_q == B;
  assign m_axi_arid    = ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = state_q == AR;
  assign m_axi_rready  = (state_q == R) & rd_ready;
  assign rd_valid      = (state_q == R) & m_axi_rvalid;
  assign rd_data       = m_axi_rdata;
  assign rd_last       = m_axi_rlast;
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = (state_q == IDLE) & ~cmd_hs;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_hs) begin
        state_d    = cmd_write ? AW : AR;
        addr_d     = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH-1);
        len_d      = cmd_len;
        beat_cnt_d = '0;
        err_d      = 1'b0;
      end
      AW: state_d = m_axi_awready ? W : AW;
      W: if (w_hs) begin
        beat_cnt_d = beat_cnt_q + 9'd1;
        state_d    = m_axi_wlast ? B : W;
      end
      B: if (m_axi_bvalid) begin
        done_valid_d = 1'b1;
        done_err_d   = err_q | (m_axi_bresp != 2'b00) | (m_axi_bid != ID);
        state_d      = IDLE;
      end
      AR: state_d = m_axi_arready ? R : AR;
      R: if (r_hs) begin
        beat_cnt_d   = beat_cnt_q + 9'd1;
        err_d        = err_q | r_bad;
        done_valid_d = m_axi_rlast;
        done_err_d   = m_axi_rlast & (err_q | r_bad);
        state_d      = m_axi_rlast ? IDLE : R;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
    end
  end
`ifdef AXI_MASTER_LAT_CNT_EN
  logic [15:0] lat_cnt_q, lat_cnt_d, lat_q, lat_d;
  logic lat_run_q, lat_run_d, ar_hs, first_r;
  assign ar_hs      = (state_q == AR) & m_axi_arready;
  assign first_r    = lat_run_q & (state_q == R) & m_axi_rvalid;
  assign lat_cycles = lat_q;
  always_comb begin
    lat_run_d = ar_hs ? 1'b1 : first_r ? 1'b0 : lat_run_q;
    lat_d     = first_r ? lat_cnt_q : lat_q;
    lat_cnt_d = ar_hs ? '0 : (lat_run_q & ~first_r & (lat_cnt_q != 16'hFFFF)) ? lat_cnt_q + 16'd1 : lat_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_run_q <= 1'b0;
      lat_cnt_q <= '0;
      lat_q     <= '0;
    end else begin
      lat_run_q <= lat_run_d;
      lat_cnt_q <= lat_cnt_d;
      lat_q     <= lat_d;
    end
  end
`endif
  // no burst splitting: a command must stay inside one 4 KB page
  a_no_4k_cross: assert property (@(posedge clk) disable iff (rst)
    cmd_hs |-> ((32'(cmd_addr[11:0]) & ~32'(STRB_WIDTH-1)) + (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH) <= 32'd4096));
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed + randomized bursts against a RAM slave, checked with a reference memory model.
module tb_axi_burst_master;
  localparam int DW = 32, ADW = 16, SW = 4, IW = 8;
  localparam logic [IW-1:0] ID = 8'h00;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_write = 0, wr_valid = 0, rd_ready = 0;
  logic [ADW-1:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic cmd_ready, wr_ready, rd_last, rd_valid, done_valid, done_err;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [ADW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready;
  logic [3:0] awcache, arcache;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic bvalid, rlast, rvalid;
`ifdef AXI_MASTER_LAT_CNT_EN
  logic [15:0] lat_cycles, lat0;
`endif
  axi_burst_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .done_valid(done_valid), .done_err(done_err),
`ifdef AXI_MASTER_LAT_CNT_EN
    .lat_cycles(lat_cycles),
`endif
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(1'b1), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(1'b1), .m_axi_bid(bid),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_arid(arid),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(1'b1), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );
  // zero-wait RAM slave with fault injection knobs and programmable first-beat read delay
  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic mem_init = 0;
  logic [1:0] inj_bresp = 0;
  logic [IW-1:0] inj_id = 0;
  int inj_early = -1, rd_delay = 0;
  logic [13:0] s_waddr, s_raddr;
  logic s_bvalid, s_ract;
  logic [1:0] s_bresp;
  logic [7:0] s_rbeat, s_rlen;
  int s_rwait;
  function automatic logic [31:0] init_word(input int i);
    return 32'h5A5A0000 ^ (32'(i) * 32'h00010003);
  endfunction
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 16384; i++) mem[i] <= init_word(i);
    if (rst) begin
      s_bvalid <= 0;
      s_ract   <= 0;
    end else begin
      if (awvalid) s_waddr <= awaddr[15:2];
      if (wvalid) begin
        for (int b = 0; b < 4; b++) if (wstrb[b]) mem[s_waddr][8*b+:8] <= wdata[8*b+:8];
        s_waddr <= s_waddr + 14'd1;
        if (wlast) begin s_bvalid <= 1; s_bresp <= inj_bresp; end
      end
      if (s_bvalid && bready) s_bvalid <= 0;
      if (arvalid) begin
        s_ract <= 1; s_rwait <= rd_delay; s_rbeat <= 0; s_rlen <= arlen; s_raddr <= araddr[15:2];
      end else if (s_ract) begin
        if (s_rwait > 0) s_rwait <= s_rwait - 1;
        else if (rready) begin
          if (rlast) s_ract <= 0;
          else s_rbeat <= s_rbeat + 8'd1;
        end
      end
    end
  end
  assign bvalid = s_bvalid;
  assign bresp  = s_bresp;
  assign bid    = ID ^ inj_id;
  assign rid    = ID ^ inj_id;
  assign rresp  = 2'b00;
  assign rvalid = s_ract && s_rwait == 0;
  assign rdata  = mem[s_raddr + 14'(s_rbeat)];
  assign rlast  = (inj_early >= 0) ? (int'(s_rbeat) == inj_early) : (s_rbeat == s_rlen);
  int tests = 0, fails = 0;
  int wr_mode = 0, rd_mode = 0, data_mode = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one command end to end; starts and ends just after a rising edge
  task automatic txn(input bit wr, input logic [15:0] addr, input logic [7:0] len, input bit exp_err,
                     input int exp_beats, input bit chk_lat, input int rst_beat);
    logic [31:0] wd [0:256];
    logic [3:0] ws [0:256];
    logic [13:0] base;
    int wi, ri, cyc;
    bit tog;
    base = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      wd[i] = data_mode == 1 ? 32'hA0 + 32'(i) : $urandom;
      ws[i] = data_mode == 2 ? 4'($urandom) : 4'hF;
    end
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      if (cmd_ready) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    wi = 0; ri = 0; tog = 1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      wr_valid = wr && wi <= int'(len) && (wr_mode == 0 || $urandom_range(0, 1) == 1);
      wr_data  = wi <= int'(len) ? wd[wi] : '0;
      wr_strb  = wi <= int'(len) ? ws[wi] : '0;
      rd_ready = rd_mode == 0 ? 1'b1 : rd_mode == 1 ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      if (rst_beat >= 0 && wi == rst_beat) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rd_valid, done_valid, cmd_ready}, 0);
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        wr_valid = 0; rd_ready = 0;
        return;
      end
      @(negedge clk);
      if (awvalid) chk("aw_fields", {awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awid},
                       {addr[15:2], 2'b00, len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, ID});
      if (arvalid) chk("ar_fields", {araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid},
                       {addr[15:2], 2'b00, len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, ID});
      if (wr_valid && wr_ready) begin
        chk("wlast", wlast, wi == int'(len));
        chk("wdata", {wvalid, wstrb, wdata}, {1'b1, ws[wi], wd[wi]});
        for (int b = 0; b < 4; b++) if (ws[wi][b]) ref_mem[base + 14'(wi)][8*b+:8] = wd[wi][8*b+:8];
        wi++;
      end
      if (rd_valid) chk("rready_mirror", rready, rd_ready);
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, ref_mem[base + 14'(ri)]);
        chk("rd_last", rd_last, ri == exp_beats - 1);
        ri++;
      end
      if (done_valid) break;
      @(posedge clk); #1;
    end
    chk("done_seen", done_valid, 1);
    chk("done_err", done_err, exp_err);
    chk("no_cmd_in_done_cycle", cmd_ready, 0);
    chk("beats", wr ? wi : ri, exp_beats);
    if (chk_lat) chk("wr_latency", cyc, int'(len) + 3);
    @(posedge clk); #1;
    wr_valid = 0; rd_ready = 0;
    chk("done_pulse_one_cycle", done_valid, 0);
    chk("cmd_ready_after_done", cmd_ready, 1);
  endtask
  initial begin
    logic [7:0] len;
    logic [15:0] addr;
    int off;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    mem_init = 1;
    repeat (3) @(posedge clk);
    #1 mem_init = 0;
    @(negedge clk);
    chk("reset_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rd_valid, done_valid, done_err}, 0);
`ifdef AXI_MASTER_LAT_CNT_EN
    chk("reset_lat", lat_cycles, 0);
`endif
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("cmd_ready_in_reset_exit", cmd_ready, 0);
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);
    data_mode = 1;
    txn(1, 16'h0103, 8'd3, 0, 4, 1, -1);
    for (int i = 0; i < 4; i++) chk("model_a0", ref_mem[14'h0040 + 14'(i)], 32'hA0 + 32'(i));
    txn(0, 16'h0100, 8'd3, 0, 4, 0, -1);
    data_mode = 0; rd_mode = 1;
    txn(1, 16'h0200, 8'd7, 0, 8, 1, -1);
    txn(0, 16'h0200, 8'd7, 0, 8, 0, -1);
    rd_mode = 0; inj_bresp = 2'b10;
    txn(1, 16'h0300, 8'd2, 1, 3, 0, -1);
    inj_bresp = 2'b00; inj_early = 1;
    txn(0, 16'h0100, 8'd3, 1, 2, 0, -1);
    inj_early = -1;
    txn(0, 16'h0100, 8'd3, 0, 4, 0, -1);
    inj_id = 8'h01;
    txn(0, 16'h0200, 8'd1, 1, 2, 0, -1);
    inj_id = 8'h00;
    txn(1, 16'h0800, 8'd7, 0, 8, 0, 2);
    txn(0, 16'h0800, 8'd7, 0, 8, 0, -1);
`ifdef AXI_MASTER_LAT_CNT_EN
    rd_delay = 0;
    txn(0, 16'h0100, 8'd3, 0, 4, 0, -1);
    lat0 = lat_cycles;
    rd_delay = 10;
    txn(0, 16'h0100, 8'd3, 0, 4, 0, -1);
    chk("lat_diff", 64'(lat_cycles) - 64'(lat0), 10);
    lat0 = lat_cycles;
    txn(1, 16'h0400, 8'd1, 0, 2, 0, -1);
    chk("lat_write_unchanged", lat_cycles, lat0);
    rd_delay = 0;
`endif
    for (int k = 0; k < 30; k++) begin
      len = 8'($urandom_range(0, 15));
      off = $urandom_range(0, 1024 - (int'(len) + 1)) * 4;
      addr = 16'($urandom_range(0, 15) * 4096 + off) | 16'($urandom_range(0, 3));
      wr_mode = $urandom_range(0, 1);
      rd_mode = $urandom_range(0, 2);
      data_mode = $urandom_range(0, 1) * 2;
      rd_delay = $urandom_range(0, 3);
      txn(1'($urandom_range(0, 1)), addr, len, 0, int'(len) + 1, 0, -1);
      txn(0, addr, len, 0, int'(len) + 1, 0, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
